minmax_sequencer: RTL and testbench
===================================

// Module: minmax_sequencer
// PURPOSE
//   Finds the unsigned minimum and maximum of a burst of N-bit samples.
//   It contains exactly one comparator_nbit instance, which is time-shared:
//   first each sample is compared against the running min, then against the
//   running max.
//   Sits between a sample source (valid/ready stream) and status logic that
//   consumes min/max/count when done pulses.
// PARAMETERS
//   N      12  sample width in bits (unsigned); passed to comparator_nbit N
//   CNT_W  8   width of the sample counter; the counter saturates
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      begin a new burst; only sampled in IDLE
//   in_valid   in   1      in_data/in_last are valid
//   in_ready   out  1      block can accept a sample this cycle
//   in_data    in   N      sample value
//   in_last    in   1      qualifies the final sample of the burst
//   min_out    out  N      running/final minimum
//   max_out    out  N      running/final maximum
//   count      out  CNT_W  samples accepted in this burst
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle pulse when the burst result is final
// BEHAVIOUR
// - All registers update on posedge clk.
// - reset=1 forces:
//   - state=IDLE
//   - min_out=0, max_out=0, count=0
//   - in_ready=0, busy=0, done=0
//   - the sample, last-flag and first-flag registers cleared
// - Reset wins over every other input in the same cycle, including
//   mid-burst; a partial result is discarded.
// - FSM states: IDLE, WAIT, CMP_MIN, CMP_MAX, DONE. Outputs are Moore:
//   - in_ready = (state==WAIT)
//   - busy     = (state!=IDLE)
//   - done     = (state==DONE)
// - IDLE:
//   - start=1: go to WAIT; clear count, min_out and max_out to 0; set first=1.
//   - start is ignored in every state other than IDLE.
// - WAIT, on handshake (in_valid & in_ready):
//   - Latch in_data into the sample register and in_last into the last-flag
//     register.
//   - If first=1: min_out=max_out=in_data, count=1, first=0. Then go to DONE
//     if in_last=1, otherwise stay in WAIT. No comparator pass is needed.
//   - Otherwise go to CMP_MIN.
// - WAIT with no handshake: stay; all registers hold.
// - CMP_MIN:
//   - Comparator a=sample, b=min_out.
//   - If smaller=1, min_out<=sample.
//   - Go to CMP_MAX.
// - CMP_MAX:
//   - Comparator a=sample, b=max_out.
//   - If greater=1, max_out<=sample.
//   - count<=count+1, saturating at 2^CNT_W-1.
//   - Go to DONE if the last-flag is set, otherwise go to WAIT.
// - DONE: lasts one cycle (done=1), then goes to IDLE. min_out, max_out and
//   count hold until the next accepted start or reset.
// - Equal values (comparator equal=1) never update min_out or max_out.
// - Comparator inputs are muxed by state; outside CMP_* the mux selects
//   (sample, min_out) and its result is ignored.
// - Latency, with T = the handshake cycle of the last sample:
//   - non-first sample: done=1 in cycle T+3
//   - single-sample burst: done=1 in cycle T+1
// - Throughput: one sample per 3 cycles after the first; in_ready=0 during
//   CMP_MIN and CMP_MAX.
// - in_last seen on a sample ends the burst; further in_valid is ignored
//   until the next start.
// TESTING
// - Reset 2 cycles, then check:
//   - min_out=max_out=0, count=0, in_ready=0, busy=0, done=0
// - start; stream 5,99,66,100,47 with in_last on 47, then check:
//   - min_out=5, max_out=100, count=5
//   - done high exactly one cycle, 3 cycles after the 47 handshake
// - start; single sample 66 with in_last, then check:
//   - min_out=max_out=66, count=1
//   - done in the cycle after the handshake
// - start; stream 0,0,0 (last on the third), then check:
//   - min_out=max_out=0, count=3
//   - no spurious update from equal compares
// - start; stream 4095,0,2048 (last), then check:
//   - min_out=0, max_out=4095, count=3 (unsigned compare)
// - Reset mid-burst; start while busy; counter saturation:
//   - after 2 samples, reset=1 -> state IDLE, all outputs 0; next burst 7,3
//     -> min_out=3, max_out=7
//   - start pulsed in WAIT has no effect
//   - with CNT_W=3, 9 samples -> count=7

Source files
------------

// File: rtl/minmax_sequencer.sv
// Streaming min/max finder built around one shared magnitude comparator.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin a new burst (honoured only in IDLE)
//   in_valid/in_ready   sample handshake; in_data is the sample,
//                       in_last marks the final sample of the burst
//   min_out/max_out     running/final unsigned min and max
//   count               samples accepted this burst (saturating)
//   busy, done          busy outside IDLE; done pulses for one cycle

module comparator_nbit #(
    parameter int N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         smaller,
    output logic         equal,
    output logic         greater
);
    assign smaller = (a < b);
    assign equal   = (a == b);
    assign greater = (a > b);
endmodule

module minmax_sequencer #(
    parameter int N     = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic [N-1:0]     min_out,
    output logic [N-1:0]     max_out,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CMP_MIN,
        CMP_MAX,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0] sample;
    logic         last_q;
    logic         first;
    logic         hs;
    logic [N-1:0] cmp_b;
    logic         cmp_lt;
    logic         cmp_eq;
    logic         cmp_gt;

    assign hs = in_valid & in_ready;

    // One comparator: the B operand follows the pass being made.
    assign cmp_b = (state == CMP_MAX) ? max_out : min_out;

    comparator_nbit #(
        .N(N)
    ) u_cmp (
        .a       (sample),
        .b       (cmp_b),
        .smaller (cmp_lt),
        .equal   (cmp_eq),
        .greater (cmp_gt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                in_ready = 1'b1;
                if (hs) begin
                    if (!first) begin
                        state_nxt = CMP_MIN;
                    end else if (in_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            CMP_MIN: state_nxt = CMP_MAX;
            CMP_MAX: state_nxt = last_q ? DONE : WAIT;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample  <= '0;
            last_q  <= 1'b0;
            first   <= 1'b0;
            min_out <= '0;
            max_out <= '0;
            count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        min_out <= '0;
                        max_out <= '0;
                        count   <= '0;
                        first   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (hs) begin
                        sample <= in_data;
                        last_q <= in_last;
                        // First sample seeds both extremes directly.
                        if (first) begin
                            min_out <= in_data;
                            max_out <= in_data;
                            count   <= CNT_W'(1);
                            first   <= 1'b0;
                        end
                    end
                end
                CMP_MIN: begin
                    if (cmp_lt && !cmp_eq) begin
                        min_out <= sample;
                    end
                end
                CMP_MAX: begin
                    if (cmp_gt && !cmp_eq) begin
                        max_out <= sample;
                    end
                    if (count != '1) begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_minmax_sequencer.sv
// Directed bench for minmax_sequencer: table of bursts plus
// hand-written sequences for reset, start-in-WAIT and saturation.

module tb_minmax_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [11:0] min_out;
    logic [11:0] max_out;
    logic [7:0]  count;
    logic        busy;
    logic        done;
    logic        in_ready3;
    logic [11:0] min3;
    logic [11:0] max3;
    logic [2:0]  count3;
    logic        busy3;
    logic        done3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    minmax_sequencer #(.N(12), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .min_out  (min_out),
        .max_out  (max_out),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    minmax_sequencer #(.N(12), .CNT_W(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready3),
        .in_data  (in_data),
        .in_last  (in_last),
        .min_out  (min3),
        .max_out  (max3),
        .count    (count3),
        .busy     (busy3),
        .done     (done3)
    );

    typedef struct {
        int               n;
        logic [8:0][11:0] s;
        logic [11:0]      mn;
        logic [11:0]      mx;
        int               cnt;
        int               cnt3;
    } vec_t;

    vec_t v[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && !in_ready; k++) begin
            tick();
        end
    endtask

    task automatic send(input logic [11:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        wait_ready();
        chk("hs_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 1;
        while (!done && k < 20) begin
            tick();
            k++;
        end
    endtask

    task automatic run_burst(input vec_t t, input string name);
        int k;
        do_start();
        for (int i = 0; i < t.n; i++) begin
            send(t.s[i], i == t.n - 1);
        end
        wait_done(k);
        chk({name, "_done"}, int'(done), 1);
        chk({name, "_lat"}, k, (t.n == 1) ? 1 : 3);
        chk({name, "_min"}, int'(min_out), int'(t.mn));
        chk({name, "_max"}, int'(max_out), int'(t.mx));
        chk({name, "_cnt"}, int'(count), t.cnt);
        chk({name, "_cnt3"}, int'(count3), t.cnt3);
        chk({name, "_min3"}, int'(min3), int'(t.mn));
        chk({name, "_max3"}, int'(max3), int'(t.mx));
        tick();
        chk({name, "_pulse"}, int'(done), 0);
        chk({name, "_idle"}, int'(busy), 0);
        chk({name, "_hold"}, int'(min_out), int'(t.mn));
    endtask

    initial begin
        int k;
        vec_t h;

        v[0].n = 5;
        v[0].s = '0;
        v[0].s[4:0] = {12'd47, 12'd100, 12'd66, 12'd99, 12'd5};
        v[0].mn = 12'd5;
        v[0].mx = 12'd100;
        v[0].cnt = 5;
        v[0].cnt3 = 5;

        v[1].n = 1;
        v[1].s = '0;
        v[1].s[0] = 12'd66;
        v[1].mn = 12'd66;
        v[1].mx = 12'd66;
        v[1].cnt = 1;
        v[1].cnt3 = 1;

        v[2].n = 3;
        v[2].s = '0;
        v[2].mn = 12'd0;
        v[2].mx = 12'd0;
        v[2].cnt = 3;
        v[2].cnt3 = 3;

        v[3].n = 3;
        v[3].s = '0;
        v[3].s[2:0] = {12'd2048, 12'd0, 12'd4095};
        v[3].mn = 12'd0;
        v[3].mx = 12'd4095;
        v[3].cnt = 3;
        v[3].cnt3 = 3;

        v[4].n = 9;
        v[4].s = {12'd2, 12'd1, 12'd9, 12'd8, 12'd7,
                  12'd30, 12'd5, 12'd20, 12'd10};
        v[4].mn = 12'd1;
        v[4].mx = 12'd30;
        v[4].cnt = 9;
        v[4].cnt3 = 7;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        tick();
        tick();
        chk("rst_min", int'(min_out), 0);
        chk("rst_max", int'(max_out), 0);
        chk("rst_cnt", int'(count), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_burst(v[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a burst discards the partial result.
        do_start();
        send(12'd11, 1'b0);
        send(12'd2, 1'b0);
        wait_ready();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", int'(busy), 0);
        chk("mid_ready", int'(in_ready), 0);
        chk("mid_min", int'(min_out), 0);
        chk("mid_max", int'(max_out), 0);
        chk("mid_cnt", int'(count), 0);
        chk("mid_done", int'(done), 0);
        h.n = 2;
        h.s = '0;
        h.s[1:0] = {12'd3, 12'd7};
        h.mn = 12'd3;
        h.mx = 12'd7;
        h.cnt = 2;
        h.cnt3 = 2;
        run_burst(h, "post_rst");

        // start while already in WAIT must not restart the burst.
        do_start();
        send(12'd50, 1'b0);
        wait_ready();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sw_cnt", int'(count), 1);
        chk("sw_min", int'(min_out), 50);
        chk("sw_ready", int'(in_ready), 1);
        send(12'd20, 1'b1);
        wait_done(k);
        chk("sw_done", int'(done), 1);
        chk("sw_min2", int'(min_out), 20);
        chk("sw_max2", int'(max_out), 50);
        chk("sw_cnt2", int'(count), 2);
        tick();

        // Samples offered after the burst ended are not accepted.
        in_valid = 1'b1;
        in_data  = 12'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("ign_ready", int'(in_ready), 0);
        chk("ign_cnt", int'(count), 2);
        chk("ign_min", int'(min_out), 20);
        chk("ign_busy3", int'(busy3), 0);
        chk("ign_ready3", int'(in_ready3), 0);
        chk("ign_done3", int'(done3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
